ws_video_timing_gen: RTL
========================

Name: ws_video_timing_gen

Overview:
- Generates the raster timing for the HDMI output path in the pixel-clock domain: horizontal/vertical counters, data-enable, syncs, frame/line strobes.
- Also generates scaled WonderSwan source coordinates, the scaled-window valid flag and the left/right border flag.
- Sits directly downstream of configPackage constants and upstream of the framebuffer reader and HDMI/TMDS encoder.
- Holds its outputs idle for a power-up interval after reset, then free-runs.

Parameters:
- H_ACTIVE, configPackage::CUSTOM_SCREEN_WIDTH (1280), visible pixels per line
- H_TOTAL, configPackage::CUSTOM_FRAME_WIDTH (1360), pixel clocks per line
- V_ACTIVE, configPackage::CUSTOM_SCREEN_HEIGHT (720), visible lines
- V_TOTAL, configPackage::CUSTOM_FRAME_HEIGHT (746), lines per frame
- HS_START, configPackage::CUSTOM_HSYNC_PULSE_START (8), front porch in pixels after H_ACTIVE
- HS_SIZE, configPackage::CUSTOM_HSYNC_PULSE_SIZE (32), hsync width in pixels
- VS_START, configPackage::CUSTOM_VSYNC_PULSE_START (12), front porch in lines after V_ACTIVE
- VS_SIZE, configPackage::CUSTOM_VSYNC_PULSE_SIZE (8), vsync width in lines
- SYNC_INV, configPackage::CUSTOM_INVERT (0), 1 = syncs active-low
- HW, configPackage::CUSTOM_BIT_WIDTH (11), hcnt width
- VW, configPackage::CUSTOM_BIT_HEIGHT (10), vcnt width
- SCALE, configPackage::SCALE (5), integer upscale factor
- SRC_W, 224, source pixels per line
- SRC_H, 144, source lines
- H_OFFSET, configPackage::COLLEN (80), left border in output pixels
- V_OFFSET, 0, top border in output lines
- PWRUP_CYCLES, configPackage::POWERUPCYCLES, idle cycles after reset

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- hcnt_o  out  HW  horizontal position, 0..H_TOTAL-1
- vcnt_o  out  VW  vertical position, 0..V_TOTAL-1
- de_o  out  1  active video
- hsync_o  out  1  horizontal sync at output polarity
- vsync_o  out  1  vertical sync at output polarity
- line_start_o  out  1  one-cycle pulse when hcnt_o==0
- frame_start_o  out  1  one-cycle pulse when hcnt_o==0 and vcnt_o==0
- src_valid_o  out  1  position lies inside the scaled source window
- src_x_o  out  8  source column, 0..SRC_W-1
- src_y_o  out  8  source row, 0..SRC_H-1
- border_o  out  1  de_o high and src_valid_o low
- running_o  out  1  power-up interval has elapsed
- lock_i  in  1  frame-lock request pulse; present only with WS_TIMING_FRAMELOCK_EN

Behaviour:
- Clocking and reset: single clock domain. A synchronous active-high rst forces state IDLE_WAIT on the next clock edge, including mid-frame.
- Reset values:
  - all counters, src_x_o, src_y_o = 0
  - de_o, line_start_o, frame_start_o, src_valid_o, border_o, running_o = 0
  - hsync_o = vsync_o = SYNC_INV, i.e. the inactive level
- FSM:
  - IDLE_WAIT: wait counter increments each cycle; outputs held at reset values.
  - When the wait counter reaches PWRUP_CYCLES-1, go to RUN on the next cycle. PWRUP_CYCLES=0 enters RUN on the first cycle after reset.
  - RUN: running_o=1; no exit except rst.
- Counters in RUN:
  - First RUN cycle presents hcnt=0, vcnt=0, with frame_start_o=1.
  - hcnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - vcnt increments on the hcnt wrap and wraps V_TOTAL-1 -> 0 on the same cycle that hcnt wraps.
- Output alignment: all outputs are registered and describe the same (hcnt_o, vcnt_o) in the same cycle. Zero skew between outputs.
- Decode:
  - de_o = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hsync is asserted for hcnt in [H_ACTIVE+HS_START, H_ACTIVE+HS_START+HS_SIZE).
  - vsync is asserted for vcnt in [V_ACTIVE+VS_START, V_ACTIVE+VS_START+VS_SIZE); it changes only on the hcnt==0 cycle.
  - Output pin level = asserted XOR SYNC_INV.
- Source window:
  - src_valid_o = hcnt in [H_OFFSET, H_OFFSET+SRC_W*SCALE) and vcnt in [V_OFFSET, V_OFFSET+SRC_H*SCALE).
  - src_x_o and src_y_o come from incremental sub-counters modulo SCALE. No divider.
  - src_x_o resets to 0 at hcnt==H_OFFSET and advances after every SCALE valid pixels.
  - src_y_o resets to 0 at line vcnt==V_OFFSET and advances after every SCALE lines.
  - Both coordinates hold their last value outside the window.
  - The final source pixel/line lasts exactly SCALE cycles/lines; there is no overrun to SRC_W or SRC_H.
- Elaboration asserts (fail elaboration if violated):
  - H_ACTIVE+HS_START+HS_SIZE <= H_TOTAL
  - V_ACTIVE+VS_START+VS_SIZE <= V_TOTAL
  - H_OFFSET+SRC_W*SCALE <= H_ACTIVE
  - V_OFFSET+SRC_H*SCALE <= V_ACTIVE
  - H_TOTAL < 2**HW and V_TOTAL < 2**VW

Optional Feature:
- Macro: WS_TIMING_FRAMELOCK_EN.
- Defined:
  - lock_i exists.
  - A lock_i pulse during RUN is latched.
  - At the next hcnt wrap, vcnt jumps to 0 instead of incrementing, and frame_start_o fires.
  - This locks output frames to the WS frame rate.
  - A lock_i pulse arriving on the wrap cycle itself applies on that same wrap.
  - lock_i is ignored in IDLE_WAIT.
- Undefined: port absent; free-running only.

Decomposition:
- Add to configPackage:
  - typedef ws_timing_t, a struct of the outputs above
  - localparams WS_SRC_W=224, WS_SRC_H=144
- The struct is consumed by the framebuffer reader and the TMDS encoder.
- One sub-module, ws_scale_counter: a modulo-SCALE divider-by-counting with start/advance/hold, instantiated once for X and once for Y.

Test Plan:
- Bench parameters: H_ACTIVE=16, H_TOTAL=24, HS_START=2, HS_SIZE=3, V_ACTIVE=6, V_TOTAL=10, VS_START=1, VS_SIZE=2, SCALE=2, SRC_W=4, SRC_H=3, H_OFFSET=4, V_OFFSET=0, PWRUP_CYCLES=5.
- Scenarios:
  1. Reset release -> 5 cycles with running_o=0 and syncs inactive; then running_o=1 and frame_start_o=1 with hcnt=0, vcnt=0.
  2. Run two frames -> frame_start_o period 240 cycles; de_o high 16 of 24 cycles on lines 0..5; hsync asserted at hcnt 18..20; vsync asserted on lines 7..8.
  3. Scan line 0 -> src_valid_o at hcnt 4..11; src_x_o sequence 0,0,1,1,2,2,3,3; border_o at hcnt 0..3 and 12..15.
  4. Lines 0..5 -> src_y_o = 0,0,1,1,2,2.
  5. SYNC_INV=1 -> hsync_o and vsync_o exactly inverted versus scenario 2; rst asserted at hcnt=10, vcnt=3 -> next cycle all outputs at reset values and the 5-cycle wait restarts.
  6. Macro defined, lock_i pulsed at vcnt=4, hcnt=7 -> cycle after hcnt=23 shows vcnt=0 and frame_start_o=1.

Source files
------------

// File: rtl/ws_video_timing_gen_pkg.sv
// Shared constants and types for the WonderSwan HDMI raster timing path.
// The ws_timing_t bundle is what the framebuffer reader and TMDS encoder consume.
package ws_video_timing_gen_pkg;

  localparam int CUSTOM_SCREEN_WIDTH      = 1280;
  localparam int CUSTOM_FRAME_WIDTH       = 1360;
  localparam int CUSTOM_SCREEN_HEIGHT     = 720;
  localparam int CUSTOM_FRAME_HEIGHT      = 746;
  localparam int CUSTOM_HSYNC_PULSE_START = 8;
  localparam int CUSTOM_HSYNC_PULSE_SIZE  = 32;
  localparam int CUSTOM_VSYNC_PULSE_START = 12;
  localparam int CUSTOM_VSYNC_PULSE_SIZE  = 8;
  localparam int CUSTOM_INVERT            = 0;
  localparam int CUSTOM_BIT_WIDTH         = 11;
  localparam int CUSTOM_BIT_HEIGHT        = 10;
  localparam int SCALE                    = 5;
  localparam int COLLEN                   = 80;
  localparam int POWERUPCYCLES            = 1024;

  localparam int WS_SRC_W = 224;
  localparam int WS_SRC_H = 144;

  typedef enum logic {
    IDLE_WAIT = 1'b0,
    RUN       = 1'b1
  } ws_timing_state_t;

  typedef struct packed {
    logic [CUSTOM_BIT_WIDTH-1:0]  hcnt;
    logic [CUSTOM_BIT_HEIGHT-1:0] vcnt;
    logic                         de;
    logic                         hsync;
    logic                         vsync;
    logic                         line_start;
    logic                         frame_start;
    logic                         src_valid;
    logic [7:0]                   src_x;
    logic [7:0]                   src_y;
    logic                         border;
    logic                         running;
  } ws_timing_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws_video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and its
// consumers (slave): framebuffer reader and TMDS encoder.
interface ws_video_timing_gen_if
  import ws_video_timing_gen_pkg::*;
#(
  parameter int HW = CUSTOM_BIT_WIDTH,
  parameter int VW = CUSTOM_BIT_HEIGHT
);

  logic [HW-1:0] hcnt_o;
  logic [VW-1:0] vcnt_o;
  logic          de_o;
  logic          hsync_o;
  logic          vsync_o;
  logic          line_start_o;
  logic          frame_start_o;
  logic          src_valid_o;
  logic [7:0]    src_x_o;
  logic [7:0]    src_y_o;
  logic          border_o;
  logic          running_o;

  modport master (
    output hcnt_o, vcnt_o, de_o, hsync_o, vsync_o, line_start_o,
           frame_start_o, src_valid_o, src_x_o, src_y_o, border_o, running_o
  );

  modport slave (
    input  hcnt_o, vcnt_o, de_o, hsync_o, vsync_o, line_start_o,
           frame_start_o, src_valid_o, src_x_o, src_y_o, border_o, running_o
  );

endinterface

// File: rtl/ws_video_timing_gen_scale_counter.sv
// Modulo-SCALE coordinate counter: turns a stream of output pixels (or lines)
// into source coordinates by counting, so no divider is needed.
// start clears to coordinate 0, advance steps one output unit, else hold.
module ws_scale_counter
  import ws_video_timing_gen_pkg::*;
#(
  parameter int SCALE = 5,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] coord
);

  localparam int            SW       = clog2_min1(SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  logic [SW-1:0] sub;

  if (SCALE < 1) begin : g_bad_scale
    $fatal(1, "ws_scale_counter: SCALE must be at least 1");
  end

  // Sub-count output units; bump the coordinate once every SCALE of them.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sub   <= '0;
      coord <= '0;
    end else if (advance) begin
      if (sub == SUB_LAST) begin
        sub   <= '0;
        coord <= coord + CW'(1);
      end else begin
        sub <= sub + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ws_video_timing_gen.sv
// Pixel-clock raster timing generator for the WonderSwan HDMI path.
// Produces counters, DE, syncs, line/frame strobes and scaled source
// coordinates, all registered and aligned to the same (hcnt, vcnt).
// Optional feature: WS_TIMING_FRAMELOCK_EN adds lock_i, which forces vcnt
// back to 0 at the next line wrap to lock output frames to the WS frame rate.
module ws_video_timing_gen
  import ws_video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE     = CUSTOM_SCREEN_WIDTH,
  parameter int H_TOTAL      = CUSTOM_FRAME_WIDTH,
  parameter int V_ACTIVE     = CUSTOM_SCREEN_HEIGHT,
  parameter int V_TOTAL      = CUSTOM_FRAME_HEIGHT,
  parameter int HS_START     = CUSTOM_HSYNC_PULSE_START,
  parameter int HS_SIZE      = CUSTOM_HSYNC_PULSE_SIZE,
  parameter int VS_START     = CUSTOM_VSYNC_PULSE_START,
  parameter int VS_SIZE      = CUSTOM_VSYNC_PULSE_SIZE,
  parameter int SYNC_INV     = CUSTOM_INVERT,
  parameter int HW           = CUSTOM_BIT_WIDTH,
  parameter int VW           = CUSTOM_BIT_HEIGHT,
  parameter int SCALE        = ws_video_timing_gen_pkg::SCALE,
  parameter int SRC_W        = WS_SRC_W,
  parameter int SRC_H        = WS_SRC_H,
  parameter int H_OFFSET     = COLLEN,
  parameter int V_OFFSET     = 0,
  parameter int PWRUP_CYCLES = POWERUPCYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef WS_TIMING_FRAMELOCK_EN
  input  logic                  lock_i,
`endif
  ws_video_timing_gen_if.master vid
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO   = HW'(H_ACTIVE + HS_START);
  localparam logic [HW-1:0] HS_LEN  = HW'(HS_SIZE);
  localparam logic [VW-1:0] VS_LO   = VW'(V_ACTIVE + VS_START);
  localparam logic [VW-1:0] VS_LEN  = VW'(VS_SIZE);
  localparam logic [HW-1:0] SX_LO   = HW'(H_OFFSET);
  localparam logic [HW-1:0] SX_LEN  = HW'(SRC_W * SCALE);
  localparam logic [VW-1:0] SY_LO   = VW'(V_OFFSET);
  localparam logic [VW-1:0] SY_LEN  = VW'(SRC_H * SCALE);
  localparam logic          INV     = (SYNC_INV != 0);
  localparam int            WW      = clog2_min1(PWRUP_CYCLES + 1);
  localparam logic [WW-1:0] W_LAST  = WW'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);

  if (H_ACTIVE + HS_START + HS_SIZE > H_TOTAL) begin : g_bad_hsync
    $fatal(1, "ws_video_timing_gen: hsync pulse extends past the line");
  end
  if (V_ACTIVE + VS_START + VS_SIZE > V_TOTAL) begin : g_bad_vsync
    $fatal(1, "ws_video_timing_gen: vsync pulse extends past the frame");
  end
  if (H_OFFSET + SRC_W * SCALE > H_ACTIVE) begin : g_bad_src_w
    $fatal(1, "ws_video_timing_gen: scaled source wider than active area");
  end
  if (V_OFFSET + SRC_H * SCALE > V_ACTIVE) begin : g_bad_src_h
    $fatal(1, "ws_video_timing_gen: scaled source taller than active area");
  end
  if (H_TOTAL >= 2 ** HW || V_TOTAL >= 2 ** VW) begin : g_bad_width
    $fatal(1, "ws_video_timing_gen: counter width too small for frame size");
  end

  ws_timing_state_t state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic             run_d;
  logic             h_wrap;
  logic             lock_hit;

  logic [HW-1:0]    hs_off, sx_off;
  logic [VW-1:0]    vs_off, sy_off;
  logic             de_d, hs_d, vs_d, sv_d, line_d, frame_d, x_in, y_in;
  logic             x_start, x_adv, y_start, y_adv;

  logic             de_q, hsync_q, vsync_q, line_q, frame_q, sv_q, border_q;
  logic [7:0]       src_x, src_y;

  assign h_wrap = (h_q == H_LAST);

`ifdef WS_TIMING_FRAMELOCK_EN
  logic lock_pend_q;

  // Hold a lock request until the next line wrap consumes it; idle ignores it.
  always_ff @(posedge clk) begin
    if (rst || state_q != RUN || h_wrap) begin
      lock_pend_q <= 1'b0;
    end else if (lock_i) begin
      lock_pend_q <= 1'b1;
    end
  end

  assign lock_hit = lock_pend_q || lock_i;
`else
  assign lock_hit = 1'b0;
`endif

  // Next state and next raster position; outputs below decode this position.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    h_d     = '0;
    v_d     = '0;
    case (state_q)
      IDLE_WAIT: begin
        if (PWRUP_CYCLES == 0 || wait_q == W_LAST) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      RUN: begin
        if (h_wrap) begin
          h_d = '0;
          v_d = (lock_hit || v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
          v_d = v_q;
        end
      end
      default: state_d = IDLE_WAIT;
    endcase
    run_d = (state_d == RUN);
  end

  // Decode the next position so the registered outputs line up with it.
  always_comb begin
    hs_off  = h_d - HS_LO;
    vs_off  = v_d - VS_LO;
    sx_off  = h_d - SX_LO;
    sy_off  = v_d - SY_LO;
    x_in    = (sx_off < SX_LEN);
    y_in    = (sy_off < SY_LEN);
    de_d    = run_d && (h_d < H_ACT) && (v_d < V_ACT);
    hs_d    = run_d && (hs_off < HS_LEN);
    vs_d    = run_d && (vs_off < VS_LEN);
    sv_d    = run_d && x_in && y_in;
    line_d  = run_d && (h_d == '0);
    frame_d = line_d && (v_d == '0);
    x_start = !run_d || (h_d == SX_LO);
    x_adv   = run_d && x_in;
    y_start = !run_d || ((h_d == '0) && (v_d == SY_LO));
    y_adv   = run_d && (h_d == '0) && y_in;
  end

  // State, counters and decoded outputs all register on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE_WAIT;
      wait_q   <= '0;
      h_q      <= '0;
      v_q      <= '0;
      de_q     <= 1'b0;
      hsync_q  <= INV;
      vsync_q  <= INV;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      sv_q     <= 1'b0;
      border_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      h_q      <= h_d;
      v_q      <= v_d;
      de_q     <= de_d;
      hsync_q  <= hs_d ^ INV;
      vsync_q  <= vs_d ^ INV;
      line_q   <= line_d;
      frame_q  <= frame_d;
      sv_q     <= sv_d;
      border_q <= de_d && !sv_d;
    end
  end

  ws_scale_counter #(.SCALE(SCALE), .CW(8)) u_scale_x (
    .clk     (clk),
    .rst     (rst),
    .start   (x_start),
    .advance (x_adv),
    .coord   (src_x)
  );

  ws_scale_counter #(.SCALE(SCALE), .CW(8)) u_scale_y (
    .clk     (clk),
    .rst     (rst),
    .start   (y_start),
    .advance (y_adv),
    .coord   (src_y)
  );

  assign vid.hcnt_o        = h_q;
  assign vid.vcnt_o        = v_q;
  assign vid.de_o          = de_q;
  assign vid.hsync_o       = hsync_q;
  assign vid.vsync_o       = vsync_q;
  assign vid.line_start_o  = line_q;
  assign vid.frame_start_o = frame_q;
  assign vid.src_valid_o   = sv_q;
  assign vid.src_x_o       = src_x;
  assign vid.src_y_o       = src_y;
  assign vid.border_o      = border_q;
  assign vid.running_o     = (state_q == RUN);

endmodule
